// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_sequencer
//  Description : Control FSM for an iterative AES encryption datapath.
//                Accepts a block (in_valid/in_ready), then steps the datapath
//                through load + initial AddRoundKey, Nr-1 full rounds and the
//                final round, and holds out_valid until the consumer takes
//                the ciphertext (out_valid/out_ready).
//  Ports       : clk, rst (sync, active-high)
//                in_valid/in_ready, key_len      - request side
//                dp_load/dp_first/dp_round/dp_final, rk_addr - datapath control
//                out_valid/out_ready             - result side
//                busy                            - high outside IDLE
//  Config      : AES_ROUND_SEQUENCER_AES256_EN - when defined, key_len=1
//                selects 14 rounds; otherwise key_len is ignored, Nr=10.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
    parameter int RK_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 key_len,
    output logic                 dp_load,
    output logic                 dp_first,
    output logic                 dp_round,
    output logic                 dp_final,
    output logic [RK_ADDR_W-1:0] rk_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] C_NR_128 = 4'd10;

    state_t     r_state;
    logic [3:0] r_round;    // current round index, 1..Nr
    logic [3:0] r_nr;       // round count latched at acceptance
    logic [3:0] w_nr_sel;   // round count selected by the incoming request
    logic       w_last_round;

`ifdef AES_ROUND_SEQUENCER_AES256_EN
    localparam logic [3:0] C_NR_256 = 4'd14;
    assign w_nr_sel = key_len ? C_NR_256 : C_NR_128;
`else
    // AES-128 only build: key_len has no function here.
    logic w_unused_key_len;
    assign w_unused_key_len = key_len;
    assign w_nr_sel         = C_NR_128;
`endif

    // Last full round is Nr-1; the step after it is the final round.
    assign w_last_round = (r_round == (r_nr - 4'd1));

    // Outputs are registered alongside the state so each one reflects the
    // state being entered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_round   <= 4'd0;
            r_nr      <= 4'd0;
            in_ready  <= 1'b1;
            dp_load   <= 1'b0;
            dp_first  <= 1'b0;
            dp_round  <= 1'b0;
            dp_final  <= 1'b0;
            rk_addr   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state  <= S_INIT;
                        r_nr     <= w_nr_sel;
                        r_round  <= 4'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        dp_load  <= 1'b1;
                        dp_first <= 1'b1;
                        rk_addr  <= '0;
                    end
                end
                S_INIT: begin
                    r_state  <= S_ROUND;
                    r_round  <= 4'd1;
                    dp_load  <= 1'b0;
                    dp_first <= 1'b0;
                    dp_round <= 1'b1;
                    rk_addr  <= RK_ADDR_W'(4'd1);
                end
                S_ROUND: begin
                    if (w_last_round) begin
                        r_state  <= S_FINAL;
                        r_round  <= r_nr;
                        dp_round <= 1'b0;
                        dp_final <= 1'b1;
                        rk_addr  <= RK_ADDR_W'(r_nr);
                    end else begin
                        r_round  <= r_round + 4'd1;
                        rk_addr  <= RK_ADDR_W'(r_round + 4'd1);
                    end
                end
                S_FINAL: begin
                    r_state   <= S_DONE;
                    r_round   <= 4'd0;
                    dp_final  <= 1'b0;
                    rk_addr   <= '0;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    // Always returns through IDLE, so a waiting requester is
                    // only accepted one cycle after the result is taken.
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_round   <= 4'd0;
                    r_nr      <= 4'd0;
                    in_ready  <= 1'b1;
                    dp_load   <= 1'b0;
                    dp_first  <= 1'b0;
                    dp_round  <= 1'b0;
                    dp_final  <= 1'b0;
                    rk_addr   <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_sequencer
//  Description : Self-checking bench for aes_round_sequencer. Expected
//                per-cycle output vectors are queued when a request is
//                driven and compared cycle by cycle on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

    localparam int RK_ADDR_W = 4;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 key_len;
    logic                 dp_load;
    logic                 dp_first;
    logic                 dp_round;
    logic                 dp_final;
    logic [RK_ADDR_W-1:0] rk_addr;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    typedef struct packed {
        logic       in_ready;
        logic       dp_load;
        logic       dp_first;
        logic       dp_round;
        logic       dp_final;
        logic       out_valid;
        logic       busy;
        logic [3:0] rk_addr;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    aes_round_sequencer #(.RK_ADDR_W(RK_ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_len   (key_len),
        .dp_load   (dp_load),
        .dp_first  (dp_first),
        .dp_round  (dp_round),
        .dp_final  (dp_final),
        .rk_addr   (rk_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.in_ready  = in_ready;
        o.dp_load   = dp_load;
        o.dp_first  = dp_first;
        o.dp_round  = dp_round;
        o.dp_final  = dp_final;
        o.out_valid = out_valid;
        o.busy      = busy;
        o.rk_addr   = rk_addr;
        return o;
    endfunction

    function automatic int nr_for(input logic kl);
`ifdef AES_ROUND_SEQUENCER_AES256_EN
        return kl ? 14 : 10;
`else
        return 10;
`endif
    endfunction

    // Reference sequence for one accepted block: INIT, Nr-1 rounds, FINAL,
    // DONE (1 + stall cycles), then one IDLE cycle.
    task automatic push_op(input int nr, input int stall);
        obs_t e;
        for (int k = 1; k <= nr + 3 + stall; k++) begin
            e = '0;
            if (k == 1) begin
                e.dp_load = 1'b1; e.dp_first = 1'b1; e.busy = 1'b1;
            end else if (k <= nr) begin
                e.dp_round = 1'b1; e.busy = 1'b1; e.rk_addr = 4'(k - 1);
            end else if (k == nr + 1) begin
                e.dp_final = 1'b1; e.busy = 1'b1; e.rk_addr = 4'(nr);
            end else if (k <= nr + 2 + stall) begin
                e.out_valid = 1'b1; e.busy = 1'b1;
            end else begin
                e.in_ready = 1'b1;
            end
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        obs_t act;
        obs_t exp_idle;
        exp_idle = '0;
        exp_idle.in_ready = 1'b1;
        rst = 1'b1; in_valid = 1'b0; key_len = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        act = sample();
        n_cmp++;
        if (act !== exp_idle) begin
            n_bad++;
            $display("FAIL reset_hold: got=%b expected=%b", act, exp_idle);
        end
        rst = 1'b0;
        @(negedge clk);
        act = sample();
        n_cmp++;
        if (act !== exp_idle) begin
            n_bad++;
            $display("FAIL reset_release_idle: got=%b expected=%b", act, exp_idle);
        end
    endtask

    // One block end to end; optional DONE backpressure and input noise.
    task automatic test_transaction(input string name, input logic kl,
                                    input int stall, input bit noise);
        int   nr;
        int   k;
        obs_t exp_o;
        obs_t act;
        nr = nr_for(kl);
        push_op(nr, stall);
        in_valid = 1'b1; key_len = kl; out_ready = 1'b1;
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            k++;
            exp_o = sb.pop_front();
            act   = sample();
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got=%b expected=%b", name, k, act, exp_o);
            end
            if (noise && k <= nr) begin
                in_valid = 1'($urandom_range(0, 1));
                key_len  = ~key_len;
            end else begin
                in_valid = 1'b0;
            end
            if (k >= nr + 2 && k <= nr + 2 + stall)
                out_ready = (k == nr + 2 + stall);
            else
                out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    // in_valid held high across two blocks: the second is accepted only
    // after an IDLE cycle, with its own key length.
    task automatic test_back_to_back(input logic kl1, input logic kl2);
        int   nr1;
        int   k;
        obs_t exp_o;
        obs_t act;
        nr1 = nr_for(kl1);
        push_op(nr1, 0);
        push_op(nr_for(kl2), 0);
        in_valid = 1'b1; key_len = kl1; out_ready = 1'b1;
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            k++;
            exp_o = sb.pop_front();
            act   = sample();
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL back_to_back cycle %0d: got=%b expected=%b", k, act, exp_o);
            end
            if (k == nr1 + 2) key_len = kl2;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        int   k;
        obs_t exp_o;
        obs_t act;
        obs_t exp_idle;
        exp_idle = '0;
        exp_idle.in_ready = 1'b1;
        push_op(10, 0);
        in_valid = 1'b1; key_len = 1'b0; out_ready = 1'b1;
        k = 0;
        while (k < 6 && sb.size() > 0) begin
            @(negedge clk);
            k++;
            exp_o = sb.pop_front();
            act   = sample();
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL mid_reset_pre cycle %0d: got=%b expected=%b", k, act, exp_o);
            end
            in_valid = 1'b0;
        end
        // Now sitting in the cycle with rk_addr=5.
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        act = sample();
        n_cmp++;
        if (act !== exp_idle) begin
            n_bad++;
            $display("FAIL mid_reset_idle: got=%b expected=%b", act, exp_idle);
        end
        rst = 1'b0;
        @(negedge clk);
        act = sample();
        n_cmp++;
        if (act !== exp_idle) begin
            n_bad++;
            $display("FAIL mid_reset_stay_idle: got=%b expected=%b", act, exp_idle);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transaction("aes128", 1'b0, 0, 1'b0);
        test_transaction("aes256", 1'b1, 0, 1'b0);
        test_transaction("backpressure", 1'b0, 5, 1'b0);
        test_transaction("input_noise128", 1'b0, 0, 1'b1);
        test_transaction("input_noise256", 1'b1, 2, 1'b1);
        test_back_to_back(1'b1, 1'b0);
        test_mid_reset();
        test_transaction("after_reset", 1'b0, 0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter RK_ADDR_W, default 4: width of the round-key address output; legal minimum 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  requester offers a block for encryption.
REQ-005 SHALL have port in_ready  output  1  sequencer can accept a block.
REQ-006 SHALL have port key_len  input  1  1 selects AES-256 (14 rounds), 0 selects AES-128 (10 rounds); sampled at acceptance.
REQ-007 SHALL have port dp_load  output  1  datapath captures the plaintext into its state register.
REQ-008 SHALL have port dp_first  output  1  datapath performs the initial AddRoundKey.
REQ-009 SHALL have port dp_round  output  1  datapath performs a full round: SubBytes, ShiftRows, MixColumns and AddRoundKey.
REQ-010 SHALL have port dp_final  output  1  datapath performs the final round, with no MixColumns.
REQ-011 SHALL have port rk_addr  output  RK_ADDR_W  round-key index for the current datapath step.
REQ-012 SHALL have port out_valid  output  1  ciphertext in the datapath is valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the ciphertext.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, INIT, ROUND, FINAL and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; acceptance occurs when in_valid&in_ready is high on a clock edge, and the FSM then moves to INIT.
REQ-017 SHALL assert dp_load=1 and dp_first=1 with rk_addr=0 for exactly one cycle in INIT, then move to ROUND with the round counter r=1.
REQ-018 SHALL assert dp_round=1 with rk_addr=r in ROUND, incrementing r each cycle from 1 to Nr-1, then move to FINAL.
REQ-019 SHALL assert dp_final=1 with rk_addr=Nr for one cycle in FINAL, then move to DONE.
REQ-020 SHALL hold out_valid=1 in DONE until out_ready=1 is sampled, then move to IDLE; there is no path from DONE directly to INIT.
REQ-021 SHALL assert out_valid on the (Nr+2)th edge after acceptance: 12 cycles for AES-128, 16 for AES-256.
REQ-022 SHALL assert at most one of dp_first, dp_round and dp_final in any cycle; all three and rk_addr SHALL be 0 in IDLE and DONE.
REQ-023 SHALL ignore in_valid and key_len changes while busy=1, and SHALL ignore out_ready outside DONE.
REQ-024 SHALL keep Nr latched for the whole operation; the round counter SHALL never exceed Nr and SHALL not wrap.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE and clear r and the latched Nr, including mid-operation; the in-flight block is discarded.
REQ-026 SHALL present these output values after reset: in_ready=1; dp_load, dp_first, dp_round, dp_final, out_valid and busy=0; rk_addr=0.

Configuration
REQ-027 SHALL support macro AES_ROUND_SEQUENCER_AES256_EN.
REQ-028 SHALL, when the macro is defined, set Nr=14 if key_len=1 at acceptance, and Nr=10 otherwise.
REQ-029 SHALL, when the macro is undefined, ignore key_len, fix Nr=10, and implement no AES-256 logic.

Verification
REQ-030 SHALL cover AES-128: in_valid=1, key_len=0, out_ready=1 -> INIT at cycle 1; rk_addr=1..9 on dp_round; rk_addr=10 on dp_final; out_valid at cycle 12; in_ready again at cycle 13.
REQ-031 SHALL cover AES-256 with the macro defined: key_len=1 -> dp_round for 13 cycles, dp_final with rk_addr=14, out_valid at cycle 16; without the macro the same stimulus yields the AES-128 sequence.
REQ-032 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held and in_ready=0 throughout; release -> IDLE on the next edge.
REQ-033 SHALL cover input noise: in_valid toggling and key_len flipping during ROUND -> no change in sequence, rk_addr or Nr.
REQ-034 SHALL cover reset mid-operation: rst=1 at rk_addr=5 -> next cycle IDLE, all outputs at reset values, and a new acceptance proceeds normally.
